bf16_to_int16: RTL and testbench
================================

# bf16_to_int16

Sequential converter from a bfloat16 operand to a saturated signed 16-bit integer. It uses truncation toward zero, matching a C cast with saturation. It sits beside the bfloat16 adder as the float-to-fixed decode stage, turning adder results back into integer data for downstream integer logic. It uses a start/ready handshake and an iterative one-bit-per-cycle shifter, so latency depends on the exponent.

## Interface
- No parameters.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  16  bfloat16 operand: sign a[15], exponent a[14:7], fraction a[6:0].
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle pulse in DONE; result and flags are valid from then on.
- result  out  16  signed two's-complement integer.
- overflow  out  1  operand was out of int16 range, or was ±inf; result is saturated.
- invalid  out  1  operand was NaN.

## Operation
- Reset values: busy=0, ready=0, result=0x0000, overflow=0, invalid=0; state is IDLE.
- **IDLE**
  - If start=1, register a, clear overflow and invalid, go to CLASSIFY.
  - If start=0, stay in IDLE.
  - result, overflow and invalid hold their last values.
- **CLASSIFY:** e=exponent, mant={1,fraction} (8 bits). Checks apply in this priority order:
  - e=0xFF, fraction≠0 (NaN): result=0x0000, invalid=1, go to DONE.
  - e=0xFF, fraction=0 (±inf): saturate, overflow=1, go to DONE.
  - e<127, including zeros and denormals: result=0x0000, go to DONE. -0 also gives 0x0000.
  - e=142, sign=1, fraction=0: result=0x8000, overflow=0, go to DONE.
  - e≥142 otherwise: saturate, overflow=1, go to DONE. Saturation gives 0x7FFF for positive operands and 0x8000 for negative ones.
  - 127≤e≤133: mag=mant, count=134−e (1..7), direction right, go to SHIFT.
  - 134≤e≤141: mag=mant, count=e−134 (0..7), direction left.
    - Go to SHIFT if count>0.
    - Go to SIGN if count=0.
- **SHIFT**
  - Each cycle shift the 16-bit mag register by 1 in the stored direction and decrement count.
  - Right shifts discard low bits (truncate).
  - Leave SHIFT for SIGN after the cycle in which count reaches 0.
  - A left shift never overflows 16 bits: the maximum magnitude is 255<<7 = 32640.
- **SIGN:** result = sign ? −mag (16-bit two's complement) : mag. Go to DONE.
- **DONE:** ready=1 for exactly this cycle, then go to IDLE.
- result, overflow and invalid are registered. They stay stable from DONE until the next accepted start.
- start is ignored while busy=1; there is no queueing.
- start is ignored during the DONE cycle as well.
- a is only sampled on the accepting edge; a may change freely at any other time.

## Timing
- Cycle numbering: cycle 1 is the first cycle after the edge that accepts start.
  - CLASSIFY is cycle 1.
  - SHIFT takes n cycles, where n is the shift count.
  - SIGN is cycle n+2.
  - DONE, with ready=1, is cycle n+3.
- Special or trivial cases go directly from CLASSIFY to DONE: ready in cycle 2.
- Normal cases: latency n+3, from 3 cycles (n=0) to 10 cycles (n=7).
- Back-to-back: start held high during DONE is ignored.
  - It is accepted on the first IDLE cycle after DONE.
  - Minimum issue interval is therefore latency+1 cycles.
- Reset asserted in any state:
  - Next edge goes to IDLE and applies all reset values.
  - ready is never asserted for the aborted conversion.
  - reset has priority over start.

## Test plan
- 0x3F80 (1.0) → 0x0001, flags 0. n=7, ready in cycle 10.
- 0xC2F6 (−123.0) → 0xFF85 with ready in cycle 4. 0x4640 (12288.0) → 0x3000 with ready in cycle 9.
- Edge values:
  - 0x4700 (32768.0) → 0x7FFF, overflow=1, ready in cycle 2.
  - 0xC700 (−32768.0) → 0x8000, overflow=0.
  - 0xC2FF (−127.5) → 0xFF81, truncated toward zero.
- Specials:
  - 0x7FC0 (NaN) → 0x0000, invalid=1.
  - 0xFF80 (−inf) → 0x8000, overflow=1.
  - 0x3F00 (0.5) → 0x0000.
  - 0x8000 (−0) → 0x0000, flags 0.
- Handshake:
  - Pulse start with 0x3F80, pulse start again in cycle 3 with 0x4700: ignored, result 0x0001.
  - Assert reset in cycle 5 of a conversion: no ready pulse, all outputs return to reset values, next start converts normally.

Source files
------------

// File: rtl/bf16_to_int16.sv
// bfloat16 -> saturated int16 converter, truncating toward zero.
// Iterative one-bit-per-cycle shifter behind a start/ready handshake.
module bf16_to_int16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  output logic        busy,
  output logic        ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        invalid
);

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    SIGN,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [15:0] a_reg;
  logic [15:0] mag;
  logic [2:0]  count;
  logic        shift_left;

  logic       sgn;
  logic [7:0] expo;
  logic [6:0] frac;
  logic [7:0] mant;

  assign sgn  = a_reg[15];
  assign expo = a_reg[14:7];
  assign frac = a_reg[6:0];
  assign mant = {1'b1, frac};

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = CLASSIFY;
      CLASSIFY: begin
        if (expo == 8'hFF || expo < 8'd127 || expo >= 8'd142)
          state_next = DONE;
        else if (expo == 8'd134)
          state_next = SIGN;
        else
          state_next = SHIFT;
      end
      SHIFT:    if (count == 3'd1) state_next = SIGN;
      SIGN:     state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg      <= '0;
      mag        <= '0;
      count      <= '0;
      shift_left <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            overflow <= 1'b0;
            invalid  <= 1'b0;
          end
        end
        CLASSIFY: begin
          if (expo == 8'hFF && frac != 7'd0) begin
            result  <= '0;
            invalid <= 1'b1;
          end else if (expo == 8'hFF) begin
            result   <= sgn ? 16'h8000 : 16'h7FFF;
            overflow <= 1'b1;
          end else if (expo < 8'd127) begin
            result <= '0;
          end else if (expo == 8'd142 && sgn && frac == 7'd0) begin
            // exactly -32768 is representable, so it is not an overflow
            result <= 16'h8000;
          end else if (expo >= 8'd142) begin
            result   <= sgn ? 16'h8000 : 16'h7FFF;
            overflow <= 1'b1;
          end else if (expo <= 8'd133) begin
            mag        <= {8'd0, mant};
            count      <= 3'(8'd134 - expo);
            shift_left <= 1'b0;
          end else begin
            mag        <= {8'd0, mant};
            count      <= 3'(expo - 8'd134);
            shift_left <= 1'b1;
          end
        end
        SHIFT: begin
          mag   <= shift_left ? (mag << 1) : (mag >> 1);
          count <= count - 3'd1;
        end
        SIGN: begin
          result <= sgn ? (16'd0 - mag) : mag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_to_int16.sv
// Self-checking bench for bf16_to_int16: directed edge values, handshake,
// reset abort and randomized operands against a value-level reference model.
module tb_bf16_to_int16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic        busy, ready, overflow, invalid;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  bf16_to_int16 dut (
    .clock(clock), .reset(reset), .start(start), .a(a),
    .busy(busy), .ready(ready), .result(result),
    .overflow(overflow), .invalid(invalid)
  );

  always #5 clock = ~clock;

  // Reference: numeric value mant*2^(e-134), truncated, then range-checked.
  function automatic void model(input logic [15:0] op, output logic [15:0] r,
                                output logic ov, output logic inv, output int lat);
    int     e;
    int     f;
    longint m;
    longint v;
    e = int'(op[14:7]);
    f = int'(op[6:0]);
    m = longint'(128 + f);
    ov = 1'b0;
    inv = 1'b0;
    r = '0;
    lat = 2;
    if (e == 255) begin
      if (f != 0) inv = 1'b1;
      else begin
        ov = 1'b1;
        r = op[15] ? 16'h8000 : 16'h7FFF;
      end
      return;
    end
    if (e < 127) return;
    if (e >= 150)      v = longint'(1) << 20;
    else if (e >= 134) v = m << (e - 134);
    else               v = m >> (134 - e);
    if (op[15]) v = -v;
    if (v > 32767)       begin r = 16'h7FFF; ov = 1'b1; end
    else if (v < -32768) begin r = 16'h8000; ov = 1'b1; end
    else                 r = 16'(v);
    if (e < 142) lat = 3 + ((e >= 134) ? (e - 134) : (134 - e));
  endfunction

  // Issues one conversion from IDLE and returns at #1 into the ready cycle.
  task automatic do_conv(input logic [15:0] op, output int lat, output logic [15:0] r,
                         output logic ov, output logic inv, output int busy_low);
    @(posedge clock); #1;
    start = 1'b1;
    a = op;
    @(posedge clock); #1;
    start = 1'b0;
    a = 16'($urandom);
    lat = -1;
    busy_low = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!busy) busy_low++;
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    r = result;
    ov = overflow;
    inv = invalid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({busy, ready, result, overflow, invalid} !== 20'h0) begin
      bad++;
      $display("FAIL reset: got busy=%b ready=%b result=%h ov=%b inv=%b, want all 0",
               busy, ready, result, overflow, invalid);
    end
    reset = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [15:0] op);
    int          lat, blow, elat;
    logic [15:0] r, er;
    logic        ov, inv, eov, einv;
    model(op, er, eov, einv, elat);
    do_conv(op, lat, r, ov, inv, blow);
    total++;
    if (lat !== elat || blow != 0) begin
      bad++;
      $display("FAIL %s latency a=%h: got %0d busy_low=%0d, want %0d busy_low=0",
               name, op, lat, blow, elat);
    end
    total++;
    if ({r, ov, inv} !== {er, eov, einv}) begin
      bad++;
      $display("FAIL %s value a=%h: got %h ov=%b inv=%b, want %h ov=%b inv=%b",
               name, op, r, ov, inv, er, eov, einv);
    end
    @(posedge clock); #1;
    total++;
    if (ready !== 1'b0 || busy !== 1'b0 || {result, overflow, invalid} !== {er, eov, einv}) begin
      bad++;
      $display("FAIL %s hold a=%h: got ready=%b busy=%b %h/%b/%b, want 0 0 %h/%b/%b",
               name, op, ready, busy, result, overflow, invalid, er, eov, einv);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ops [10] = '{16'h3F80, 16'hC2F6, 16'h4640, 16'h4700, 16'hC700,
                              16'hC2FF, 16'h7FC0, 16'hFF80, 16'h3F00, 16'h8000};
    foreach (ops[i]) check_op("directed", ops[i]);
  endtask

  task automatic test_random;
    logic [15:0] op;
    for (int i = 0; i < 150; i++) begin
      op = 16'($urandom);
      if (i % 2 == 0) op[14:7] = 8'($urandom_range(124, 145));
      check_op("random", op);
    end
  endtask

  task automatic test_ignored_start;
    int lat = -1;
    @(posedge clock); #1;
    start = 1'b1;
    a = 16'h3F80;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        start = 1'b1;
        a = 16'h4700;
      end else begin
        start = 1'b0;
      end
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    total++;
    if (lat !== 10 || {result, overflow, invalid} !== {16'h0001, 2'b00}) begin
      bad++;
      $display("FAIL ignored_start: got lat=%0d %h ov=%b inv=%b, want lat=10 0001 0 0",
               lat, result, overflow, invalid);
    end
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored_start_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset_abort;
    int          lat, blow, seen;
    logic [15:0] r;
    logic        ov, inv;
    do_conv(16'h4700, lat, r, ov, inv, blow);
    @(posedge clock); #1;
    start = 1'b1;
    a = 16'h3F80;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      if (ready) seen++;
      if (c == 5) reset = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    total++;
    if ({busy, ready, result, overflow, invalid} !== 20'h0) begin
      bad++;
      $display("FAIL reset_abort: got busy=%b ready=%b result=%h ov=%b inv=%b, want all 0",
               busy, ready, result, overflow, invalid);
    end
    for (int c = 0; c < 12; c++) begin
      if (ready) seen++;
      @(posedge clock); #1;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_abort_ready: got %0d ready pulses, want 0", seen);
    end
    do_conv(16'hC2F6, lat, r, ov, inv, blow);
    total++;
    if (lat !== 4 || {r, ov, inv} !== {16'hFF85, 2'b00}) begin
      bad++;
      $display("FAIL reset_recover: got lat=%0d %h ov=%b inv=%b, want lat=4 ff85 0 0",
               lat, r, ov, inv);
    end
  endtask

  task automatic test_back_to_back;
    int lat = -1;
    @(posedge clock); #1;
    start = 1'b1;
    a = 16'hC2F6;
    @(posedge clock); #1;
    for (int c = 1; c <= 20; c++) begin
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    total++;
    if (lat !== 4 || result !== 16'hFF85) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d %h, want lat=4 ff85", lat, result);
    end
    @(posedge clock); #1;
    a = 16'h4640;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: got busy=%b, want 0", busy);
    end
    @(posedge clock); #1;
    start = 1'b0;
    a = 16'h0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    total++;
    if (lat !== 9 || {result, overflow, invalid} !== {16'h3000, 2'b00}) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d %h ov=%b inv=%b, want lat=9 3000 0 0",
               lat, result, overflow, invalid);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
